// File: rtl/sha256_round_pipe.sv
// Unrolled SHA-256 round pipeline: two slices per round, one block per clock.
// Ports: clk, rst_n, flush, in_valid, i_state, i_data, in_tag -> out_valid, out_state, out_tag, out_hit.
// Optional macro SHA256_FEEDFWD_EN adds i_state into the result (compression output).
module sha256_round_pipe #(
  parameter int          STAGES      = 64,
  parameter int          FIRST_ROUND = 0,
  parameter int          TAG_W       = 32,
  parameter logic [31:0] HIT_MASK    = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [255:0]     i_state,
  input  logic [511:0]     i_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [255:0]     out_state,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_hit
);

  // Trailing zero lets the last round fetch K[64] without a range guard.
  localparam logic [31:0] K [65] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2,
    32'h00000000
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ep0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction
  function automatic logic [31:0] ep1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction
  function automatic logic [31:0] sg0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sg1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, f, g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, b, c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Index 0 of the b_* arrays is the input register.
  logic [31:0]      b_st  [STAGES+1][8];
  logic [31:0]      b_w   [STAGES+1][16];
  logic [31:0]      b_t1p [STAGES+1];
  logic [TAG_W-1:0] b_tag [STAGES+1];
  logic [STAGES:0]  b_v;
  logic [31:0]      a_st  [STAGES][8];
  logic [31:0]      a_w   [STAGES][16];
  logic [31:0]      a_t1  [STAGES];
  logic [31:0]      a_p   [STAGES];
  logic [TAG_W-1:0] a_tag [STAGES];
  logic [STAGES-1:0] a_v;
`ifdef SHA256_FEEDFWD_EN
  logic [31:0]      b_ff  [STAGES+1][8];
  logic [31:0]      a_ff  [STAGES][8];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_v <= '0;
      a_v <= '0;
    end else if (flush) begin
      b_v <= '0;
      a_v <= '0;
    end else begin
      b_v <= {a_v, in_valid};
      a_v <= b_v[STAGES-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      b_st[0][k] <= i_state[32*k +: 32];
`ifdef SHA256_FEEDFWD_EN
      b_ff[0][k] <= i_state[32*k +: 32];
`endif
    end
    for (int k = 0; k < 16; k++)
      b_w[0][k] <= i_data[32*k +: 32];
    b_t1p[0] <= i_state[255:224] + i_data[31:0] + K[FIRST_ROUND];
    b_tag[0] <= in_tag;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_rnd
    localparam int R = FIRST_ROUND + i;
    always_ff @(posedge clk) begin
      // slice A: T1 and first half of the schedule sum
      a_st[i]  <= b_st[i];
      a_w[i]   <= b_w[i];
      a_tag[i] <= b_tag[i];
      a_t1[i]  <= ch(b_st[i][4], b_st[i][5], b_st[i][6])
                + ep1(b_st[i][4]) + b_t1p[i];
      a_p[i]   <= sg0(b_w[i][1]) + b_w[i][0] + b_w[i][9];
`ifdef SHA256_FEEDFWD_EN
      a_ff[i]  <= b_ff[i];
      b_ff[i+1] <= a_ff[i];
`endif
      // slice B: new a/e, word shift, window roll, next t1_p
      b_st[i+1][0] <= maj(a_st[i][0], a_st[i][1], a_st[i][2])
                    + ep0(a_st[i][0]) + a_t1[i];
      b_st[i+1][1] <= a_st[i][0];
      b_st[i+1][2] <= a_st[i][1];
      b_st[i+1][3] <= a_st[i][2];
      b_st[i+1][4] <= a_st[i][3] + a_t1[i];
      b_st[i+1][5] <= a_st[i][4];
      b_st[i+1][6] <= a_st[i][5];
      b_st[i+1][7] <= a_st[i][6];
      for (int j = 0; j < 15; j++)
        b_w[i+1][j] <= a_w[i][j+1];
      b_w[i+1][15] <= sg1(a_w[i][14]) + a_p[i];
      // next round's h is this round's g
      b_t1p[i+1] <= a_st[i][6] + a_w[i][1] + K[R+1];
      b_tag[i+1] <= a_tag[i];
    end
  end

  logic [255:0] fin;
  logic         hit_c;

  always_comb begin
    fin = '0;
    for (int k = 0; k < 8; k++) begin
`ifdef SHA256_FEEDFWD_EN
      fin[32*k +: 32] = b_st[STAGES][k] + b_ff[STAGES][k];
`else
      fin[32*k +: 32] = b_st[STAGES][k];
`endif
    end
  end

  assign hit_c = (fin[255:224] & HIT_MASK) == 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_state <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= b_v[STAGES] & ~flush;
      out_hit   <= b_v[STAGES] & ~flush & hit_c;
      if (b_v[STAGES]) begin
        out_state <= fin;
        out_tag   <= b_tag[STAGES];
      end
    end
  end

endmodule
